// File: rtl/tlb_walker.sv
// Two-level page-table walker feeding the TLB update port.
// Optional superpage leaves at L1 when TLB_WALKER_SUPERPAGE_EN is defined.
module tlb_walker #(
    parameter int ADDR_WIDTH       = 32,
    parameter int PAGE_OFFSET_BITS = 12,
    parameter int L1_INDEX_BITS    = 10,
    parameter int ASID_WIDTH       = 8,
    localparam int VPN_BITS        = ADDR_WIDTH - PAGE_OFFSET_BITS,
    localparam int L2_BITS         = VPN_BITS - L1_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [VPN_BITS-1:0]   miss_vpage_idx,
    input  logic [ASID_WIDTH-1:0] miss_asid,
    input  logic [ADDR_WIDTH-1:0] page_dir_base,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  update_en,
    input  logic                  update_ack,
    output logic [VPN_BITS-1:0]   update_vpage_idx,
    output logic [ASID_WIDTH-1:0] update_asid,
    output logic [VPN_BITS-1:0]   update_ppage_idx,
    output logic                  update_present,
    output logic                  update_exe_writable,
    output logic                  update_supervisor,
    output logic                  update_global,
    output logic                  walk_fault,
    output logic                  walk_busy
);

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, FILL, FAULT
    } state_t;

    state_t                r_state;
    logic [VPN_BITS-1:0]   r_vpage;
    logic [ASID_WIDTH-1:0] r_asid;

    logic [ADDR_WIDTH-1:0] w_l1_off;
    logic [ADDR_WIDTH-1:0] w_l2_base;
    logic [ADDR_WIDTH-1:0] w_l2_off;
    logic                  w_in_req;
    logic                  w_unused;

    assign w_l1_off  = ADDR_WIDTH'({miss_vpage_idx[VPN_BITS-1 -: L1_INDEX_BITS], 2'b00});
    assign w_l2_base = ADDR_WIDTH'({mem_rdata[31:PAGE_OFFSET_BITS], {PAGE_OFFSET_BITS{1'b0}}});
    assign w_l2_off  = ADDR_WIDTH'({r_vpage[L2_BITS-1:0], 2'b00});
    assign w_in_req  = (r_state == L1_REQ) || (r_state == L2_REQ);
    assign w_unused  = ^mem_rdata[11:4];

    assign update_vpage_idx = r_vpage;
    assign update_asid      = r_asid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= IDLE;
            r_vpage             <= '0;
            r_asid              <= '0;
            miss_ready          <= 1'b1;
            mem_read_en         <= 1'b0;
            mem_addr            <= '0;
            update_en           <= 1'b0;
            update_ppage_idx    <= '0;
            update_present      <= 1'b0;
            update_exe_writable <= 1'b0;
            update_supervisor   <= 1'b0;
            update_global       <= 1'b0;
            walk_fault          <= 1'b0;
            walk_busy           <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (miss_valid) begin
                        r_vpage     <= miss_vpage_idx;
                        r_asid      <= miss_asid;
                        mem_addr    <= page_dir_base + w_l1_off;
                        mem_read_en <= 1'b1;
                        miss_ready  <= 1'b0;
                        walk_busy   <= 1'b1;
                        r_state     <= L1_REQ;
                    end
                end
                L1_REQ: begin
                    if (mem_ready) begin
                        mem_read_en <= 1'b0;
                        r_state     <= L1_WAIT;
                    end
                end
                L1_WAIT: begin
                    if (mem_rvalid) begin
                        if (!mem_rdata[0]) begin
                            walk_fault <= 1'b1;
                            r_state    <= FAULT;
`ifdef TLB_WALKER_SUPERPAGE_EN
                        end else if (mem_rdata[4]) begin
                            // Leaf at L1: low vpage bits pass through as page offset within the superpage
                            update_ppage_idx    <= {mem_rdata[31 -: L1_INDEX_BITS],
                                                    r_vpage[L2_BITS-1:0]};
                            update_present      <= mem_rdata[0];
                            update_exe_writable <= mem_rdata[1];
                            update_supervisor   <= mem_rdata[2];
                            update_global       <= mem_rdata[3];
                            update_en           <= 1'b1;
                            r_state             <= FILL;
`endif
                        end else begin
                            mem_addr    <= w_l2_base + w_l2_off;
                            mem_read_en <= 1'b1;
                            r_state     <= L2_REQ;
                        end
                    end
                end
                L2_REQ: begin
                    if (mem_ready) begin
                        mem_read_en <= 1'b0;
                        r_state     <= L2_WAIT;
                    end
                end
                L2_WAIT: begin
                    // Non-present leaves are still filled so the TLB can report them
                    if (mem_rvalid) begin
                        update_ppage_idx    <= mem_rdata[31 -: VPN_BITS];
                        update_present      <= mem_rdata[0];
                        update_exe_writable <= mem_rdata[1];
                        update_supervisor   <= mem_rdata[2];
                        update_global       <= mem_rdata[3];
                        update_en           <= 1'b1;
                        r_state             <= FILL;
                    end
                end
                FILL: begin
                    if (update_ack) begin
                        update_en  <= 1'b0;
                        miss_ready <= 1'b1;
                        walk_busy  <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                FAULT: begin
                    walk_fault <= 1'b0;
                    miss_ready <= 1'b1;
                    walk_busy  <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    a_no_rvalid_in_req: assert property (
        @(posedge clk) disable iff (!reset) !(w_in_req && mem_rvalid && mem_ready));

endmodule

// File: doc/tlb_walker.md
Name: tlb_walker

Overview:
Hardware page-table walker that sits directly upstream of the TLB update port. On a TLB miss it walks a two-level in-memory page table and produces one TLB fill with ppage, flags and ASID, or a fault. It has one outstanding memory read at a time and one walk in flight.

Parameters:
ADDR_WIDTH, 32, physical/virtual address width.
PAGE_OFFSET_BITS, 12, page offset width; vpage width VPN_BITS = ADDR_WIDTH - PAGE_OFFSET_BITS (20).
L1_INDEX_BITS, 10, upper vpage bits indexing the page directory; L2 index = VPN_BITS - L1_INDEX_BITS.
ASID_WIDTH, 8, address-space ID width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
miss_valid  in  1  walk request
miss_ready  out  1  walker idle, request accepted when miss_valid && miss_ready
miss_vpage_idx  in  VPN_BITS  faulting virtual page
miss_asid  in  ASID_WIDTH  requesting ASID
page_dir_base  in  ADDR_WIDTH  physical page-directory base, sampled at accept
mem_read_en  out  1  memory read request
mem_addr  out  ADDR_WIDTH  word-aligned PTE address
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  PTE read data
update_en  out  1  TLB fill request, held until update_ack
update_ack  in  1  TLB port granted this cycle
update_vpage_idx  out  VPN_BITS  fill vpage
update_asid  out  ASID_WIDTH  fill ASID
update_ppage_idx  out  VPN_BITS  fill ppage
update_present / update_exe_writable / update_supervisor / update_global  out  1 each  fill flags
walk_fault  out  1  one-cycle pulse: L1 entry not present
walk_busy  out  1  state != IDLE

Behaviour:
- PTE format: [31:12] ppage or L2 table base; bit0 present; bit1 exe_writable; bit2 supervisor; bit3 global; bit4 superpage (see optional feature).
- Reset (reset low, async): state=IDLE; mem_read_en=0, update_en=0, walk_fault=0, walk_busy=0, miss_ready=1; data outputs 0.
- FSM: IDLE -> L1_REQ -> L1_WAIT -> L2_REQ -> L2_WAIT -> FILL -> IDLE; L1_WAIT -> FAULT -> IDLE.
- IDLE: miss_ready=1. On accept, latch vpage, asid, page_dir_base; next L1_REQ.
- L1_REQ: mem_read_en=1, mem_addr = page_dir_base + (vpage[VPN_BITS-1 -: L1_INDEX_BITS] << 2). Hold address stable until mem_ready; then L1_WAIT.
- L1_WAIT: on mem_rvalid, if rdata[0]=0 -> FAULT; else latch L2 base = {rdata[31:12], 12'b0}; next L2_REQ.
- L2_REQ: mem_addr = L2 base + (vpage[L2 index bits] << 2); handshake as L1_REQ.
- L2_WAIT: on mem_rvalid latch ppage and flags from rdata; -> FILL. A non-present L2 entry is still filled (present=0) so the TLB reports a not-present hit.
- FILL: update_en=1 with all update_* stable until update_ack; on ack -> IDLE, miss_ready rises next cycle. Minimum latency accept -> update_en is 4 cycles with zero-wait memory.
- FAULT: walk_fault=1 for exactly one cycle, no update_en; -> IDLE.
- mem_rvalid outside a WAIT state is ignored. mem_rvalid coincident with mem_ready in a REQ state is not permitted (assert).
- miss_valid while busy is not accepted; requester holds it.
- update_en and mem_read_en never assert together; update_en is never asserted outside FILL.
- Reset mid-walk aborts immediately. Any in-flight memory response arriving after reset release is ignored because state is IDLE.

Optional Feature:
TLB_WALKER_SUPERPAGE_EN. Defined: in L1_WAIT a present entry with rdata[4]=1 skips L2 and goes to FILL with ppage = {rdata[31:31-L1_INDEX_BITS+1], vpage[L2 index bits]} and flags from the L1 entry. Undefined: bit4 is ignored and every present L1 entry is treated as a table pointer.

Test Plan:
- page_dir_base=0x1000, vpage=0x00403, L1[1]=0x00002001, L2[3]=0x0000500B -> reads at 0x1004 then 0x200C; update_en with ppage=0x00005, present=1, exe_writable=1, supervisor=0, global=1.
- L1 entry 0x0 -> single read, walk_fault pulses for 1 cycle, no update_en, miss_ready=1 the following cycle.
- mem_ready held low 5 cycles in L1_REQ -> mem_addr stable, one read issued; update_ack delayed 3 cycles -> update_* stable throughout, a single fill.
- Second miss_valid while busy -> miss_ready=0 until FILL is acked; second walk then completes correctly.
- reset low during L2_WAIT, stray mem_rvalid after release -> state IDLE, no update_en, no fault.
- With TLB_WALKER_SUPERPAGE_EN, L1[1]=0x00C00013, vpage=0x00403 -> one memory read, ppage=0x00C03, present=1, exe_writable=1.
